// File: rtl/fp_addsub_if.sv
// fp_addsub_if: operand/result handshake bundle for the floating-point add/subtract pipeline
interface fp_addsub_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_sum;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [2:0] out_flags;
  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag, out_flags
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag, out_flags
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage IEEE-754-style add/subtract with round-to-nearest-even and tag pass-through
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst_n,
  fp_addsub_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int F = MAN_W + 4;
  localparam int XW = EXP_W + $clog2(MAN_W + 4) + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  typedef struct packed {
    logic v;
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [F-1:0] xa, ya;
    logic sub, nz, spec, inv;
    logic [W-1:0] sval;
    logic [TAG_W-1:0] tag;
  } s1_t;
  typedef struct packed {
    logic v;
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [F:0] sum;
    logic nz, spec, inv;
    logic [W-1:0] sval;
    logic [TAG_W-1:0] tag;
  } s2_t;
  s1_t s1, s1_n;
  s2_t s2, s2_n;
  logic en;
  logic [W-1:0] b;
  logic sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, swap;
  logic [EXP_W-1:0] ea, eb, d;
  logic [MAN_W:0] fa, fb;
  logic [F-1:0] wide, mask, n;
  logic [XW-1:0] lz;
  logic signed [XW-1:0] e_n, e_f;
  logic [MAN_W+1:0] mr;
  logic g, r, s;
  logic [W-1:0] res;
  logic [2:0] flags;
  assign en = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;
  // Stage 1: unpack, classify specials, order by magnitude and align the smaller operand with sticky
  always_comb begin
    b = {bus.in_b[W-1] ^ bus.in_sub, bus.in_b[W-2:0]};
    sa = bus.in_a[W-1];
    sb = b[W-1];
    ea = bus.in_a[W-2:MAN_W];
    eb = b[W-2:MAN_W];
    za = ea == '0;
    zb = eb == '0;
    fa = za ? '0 : {1'b1, bus.in_a[MAN_W-1:0]};
    fb = zb ? '0 : {1'b1, b[MAN_W-1:0]};
    nan_a = (ea == EMAX) && (bus.in_a[MAN_W-1:0] != '0);
    nan_b = (eb == EMAX) && (b[MAN_W-1:0] != '0);
    inf_a = (ea == EMAX) && !nan_a;
    inf_b = (eb == EMAX) && !nan_b;
    swap = {eb, fb} > {ea, fa};
    d = swap ? eb - ea : ea - eb;
    wide = {swap ? fa : fb, 3'b000};
    mask = ~({F{1'b1}} << d);
    s1_n.v = bus.in_valid;
    s1_n.sign = swap ? sb : sa;
    s1_n.exp = swap ? eb : ea;
    s1_n.xa = {swap ? fb : fa, 3'b000};
    s1_n.ya = (wide >> d) | {{(F-1){1'b0}}, |(wide & mask)};
    s1_n.sub = sa ^ sb;
    s1_n.nz = za & zb & sa & sb;
    s1_n.spec = (ea == EMAX) | (eb == EMAX);
    s1_n.inv = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
    s1_n.sval = s1_n.inv ? QNAN : {inf_a ? sa : sb, EMAX, {MAN_W{1'b0}}};
    s1_n.tag = bus.in_tag;
  end
  // Stage 2: magnitude add or subtract; the larger operand is X so the difference never goes negative
  always_comb begin
    s2_n.v = s1.v;
    s2_n.sign = s1.sign;
    s2_n.exp = s1.exp;
    s2_n.sum = s1.sub ? {1'b0, s1.xa} - {1'b0, s1.ya} : {1'b0, s1.xa} + {1'b0, s1.ya};
    s2_n.nz = s1.nz;
    s2_n.spec = s1.spec;
    s2_n.inv = s1.inv;
    s2_n.sval = s1.sval;
    s2_n.tag = s1.tag;
  end
  // Stage 3: normalise (left by leading zeros or right on carry), round to nearest even, pack and flag
  always_comb begin
    lz = '0;
    for (int i = 0; i < F; i++) if (s2.sum[i]) lz = XW'(F - 1 - i);
    n = s2.sum[F] ? {s2.sum[F:2], s2.sum[1] | s2.sum[0]} : s2.sum[F-1:0] << lz;
    e_n = $signed(XW'(s2.exp)) + $signed(XW'(s2.sum[F])) - $signed(lz);
    {g, r, s} = n[2:0];
    mr = {1'b0, n[F-1:3]} + (MAN_W+2)'(g & (r | s | n[3]));
    e_f = e_n + $signed(XW'(mr[MAN_W+1]));
    res = {s2.sign, e_f[EXP_W-1:0], mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0]};
    flags = {2'b00, g | r | s};
    if (s2.spec) begin
      res = s2.sval;
      flags = {s2.inv, 2'b00};
    end else if (s2.sum == '0) begin
      res = {s2.nz, {(W-1){1'b0}}};
      flags = '0;
    end else if (e_f >= $signed(XW'(EMAX))) begin
      res = {s2.sign, EMAX, {MAN_W{1'b0}}};
      flags = 3'b011;
    end else if (e_f <= 0) begin
      res = {s2.sign, {(W-1){1'b0}}};
      flags = 3'b001;
    end
  end
  // Pipeline registers: everything advances together when the output slot is free or being taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sum <= '0;
      bus.out_tag <= '0;
      bus.out_flags <= '0;
    end else if (en) begin
      s1 <= s1_n;
      s2 <= s2_n;
      bus.out_valid <= s2.v;
      bus.out_sum <= res;
      bus.out_tag <= s2.tag;
      bus.out_flags <= flags;
    end
  end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point add/subtract unit for the Q-value update datapath.
- Accepts one operand pair per cycle and returns one result per cycle.
- Supports add or subtract per operation, round-to-nearest-even, and correct zero, overflow and Inf/NaN handling.
- Uses valid/ready handshakes on both sides and carries an opaque tag to match results with requests.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (hidden bit excluded); word width W = 1+EXP_W+MAN_W
TAG_W, 4, width of the pass-through tag

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair present
in_ready  out  1  unit accepts the pair this cycle
in_a  in  W  operand A
in_b  in  W  operand B
in_sub  in  1  0: A+B, 1: A-B (B sign inverted at stage 1)
in_tag  in  TAG_W  tag returned with the result
out_valid  out  1  result present
out_ready  in  1  consumer accepts the result
out_sum  out  W  result
out_tag  out  TAG_W  tag of the result
out_flags  out  3  {invalid, overflow, inexact}

Behaviour:
- Reset, asynchronous while rst_n=0:
  - All stage valid bits clear.
  - out_valid=0, out_sum=0, out_tag=0, out_flags=0.
  - in_ready=1 once rst_n=1; it is combinational from out_valid/out_ready.
- Global advance enable: en = !out_valid | out_ready; in_ready = en.
  - When en=1, every stage shifts forward. Bubbles propagate; they are not squeezed out.
  - When en=0, all stage registers hold.
- Transfer rules:
  - An input transfers when in_valid & in_ready.
  - An output transfers when out_valid & out_ready.
  - out_sum, out_tag and out_flags stay stable while out_valid=1 & out_ready=0.
- Latency is exactly 3 cycles from input transfer to out_valid, with no stall. Throughput is 1 per cycle.
- Stage 1, unpack/align:
  - Apply in_sub to B's sign.
  - Exponent field 0 means the operand is zero; denormals flush to signed zero.
  - Swap so the larger magnitude is X (compare exponent, then mantissa).
  - Right-shift Y's mantissa (hidden bit included) by the exponent difference into MAN_W+4 bits: mantissa, guard, round, sticky. Bits shifted out OR into sticky.
  - A shift of MAN_W+3 or more leaves only sticky.
- Stage 2, add:
  - Same effective signs: add. Different signs: subtract (X-Y, never negative).
  - Result sign = X sign.
  - Carry-out sets a 1-bit right normalise flag.
- Stage 3, normalise/round/pack:
  - Leading-zero count with a left shift, or a 1-bit right shift on carry, adjusting the exponent.
  - Round to nearest, ties to even, on guard/round/sticky. A rounding carry renormalises.
  - Exact zero result: +0, except -0 when both effective operands are -0.
  - Exponent ≥ all-ones: signed Inf, overflow=1, inexact=1.
  - Exponent ≤ 0: signed zero, inexact=1.
  - inexact=1 whenever any of guard/round/sticky is nonzero.
- Special inputs (exponent all-ones):
  - Any NaN, or Inf + (−Inf) after in_sub: canonical quiet NaN {0, all-ones exp, 1, zeros}, invalid=1.
  - Otherwise one Inf: that Inf, flags 0.
  - Special-case decisions are computed in stage 1 and carried alongside the data.
- Reset mid-operation discards all in-flight results; no output appears after release until new inputs are accepted.

Test Plan:
- Basic add: default params, A=0x3F800000, B=0x40000000, sub=0, tag=5. Required: out_sum=0x40400000, tag 5, flags 000, exactly 3 cycles later.
- Subtract and zero: A=0x40200000, B=0x3F000000, sub=1 gives 0x40000000. Then A=B=0x3F800000, sub=1 gives 0x00000000 (+0), flags 000.
- Rounding: 0x3F800000 + 0x33800000 (tie) gives 0x3F800000 with inexact=1. 0x3F800001 + 0x33800000 gives 0x3F800002 (tie rounds to even).
- Overflow/special: 0x7F7FFFFF + 0x7F7FFFFF gives 0x7F800000 with overflow, inexact. 0x7F800000 − 0x7F800000 gives 0x7FC00000 with invalid=1. Infinity plus 1.0 gives 0x7F800000.
- Back-pressure: stream 8 tagged ops with out_ready toggled randomly and held low for 5 cycles. Required: in_ready falls while stalled, no loss or duplication, results in order, outputs stable during stall, tags in sequence.
- Reset mid-flight: accept 2 ops, assert rst_n=0 for 1 cycle. Required: out_valid=0 immediately; no stale results after release.
